vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Raster timing master for the VGA path on the DE0 board.
- Generates horizontal/vertical counters and drives xPos/yPos to the pixel generators.
- Accepts their registered colour back and aligns HSYNC/VSYNC/blanking to that colour by a configurable pipeline delay.
- Drives blanked RGB to the DAC pins. Default timing is 640x480@60 with vga_clk = 25.175 MHz (25 MHz accepted).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIX_LAT, 1, clocks from xPos/yPos to valid colour at red_in/green_in/blue_in; range 0..4

Ports:
vga_clk  in  1  pixel clock
RST  in  1  asynchronous reset, active-low
xPos  out  10  current horizontal count, 0..H_TOTAL-1
yPos  out  10  current vertical count, 0..V_TOTAL-1
red_in  in  4  colour from pixel generator, PIX_LAT clocks after xPos/yPos
green_in  in  4  as above
blue_in  in  4  as above
vga_r  out  4  blanked red to DAC
vga_g  out  4  blanked green
vga_b  out  4  blanked blue
vga_hs  out  1  hsync, active-low
vga_vs  out  1  vsync, active-low
disp_en  out  1  high while vga_r/g/b carry an active pixel
frame_start  out  1  one-clock pulse, aligned with xPos=0,yPos=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both counters are 10 bits.
- Reset (RST low, async): h_cnt=0, v_cnt=0, delay-line stages cleared to hs=1, vs=1, de=0.
  - Outputs while in reset: xPos=0, yPos=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, disp_en=0, frame_start=0.
- Counting: h_cnt increments each clock and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - Simultaneous wrap of both counters (799,524) -> (0,0) in one clock.
- xPos=h_cnt and yPos=v_cnt, both registered. They run through blanking; generators must not rely on them being clamped.
- Raw timing decode from the counters:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_raw low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for whole lines, changing at h_cnt=0.
- Alignment: active, hs_raw and vs_raw pass through a PIX_LAT-stage shift register.
  - PIX_LAT=0 means combinational pass-through.
- Output stage: one register clocked by vga_clk.
  - vga_hs = delayed hs; vga_vs = delayed vs; disp_en = delayed active.
  - vga_r/g/b = *_in when delayed active, else 0.
  - Total latency from xPos change to the matching pins is PIX_LAT+1 clocks, identical for sync, disp_en and colour.
- frame_start is registered high for exactly one clock while xPos=0 and yPos=0 are presented. It is not delayed.
- Reset mid-frame: all state returns to reset values immediately. Counting restarts from (0,0) on the first vga_clk edge after RST deasserts; no partial sync pulse is emitted.
- Colour inputs are ignored, and outputs forced to 0, during every blanking clock, including porches and sync.

Optional Feature:
Macro VGA_FRAME_COUNTER_EN.
- Defined: adds output frame_cnt (16 bits). It resets to 0, increments on each frame_start pulse (registered, visible the clock after the pulse), and wraps 0xFFFF -> 0.
- Undefined: the port and its logic do not exist; all other behaviour is unchanged.

Decomposition:
- Package vga_timing_pkg: default 640x480@60 constants (H_*/V_* values, H_TOTAL, V_TOTAL), the colour width 4, and the counter width 10.
- One sub-module, vga_pipe_delay: parameterised depth, async active-low reset value per bit. Used for the hs/vs/de alignment line.

Test Plan:
- Hold RST low 10 clocks, mid-frame at xPos=300 -> vga_hs=1, vga_vs=1, disp_en=0, RGB=0. After release, xPos counts 0,1,2,...
- Free run, PIX_LAT=1 -> vga_hs low for exactly 96 clocks per line, first low 2 clocks after xPos==656. Line period is 800 clocks.
- Free run -> vga_vs low for exactly 2 lines (1600 clocks), starting 2 clocks after yPos==490,xPos==0. Frame period is 420000 clocks.
- red/green/blue_in=4'hF constant -> disp_en high exactly 640 clocks per visible line and 480 lines per frame. RGB=F only while disp_en=1, else 0.
- Generator returning 4'hF for 213<x<426, 160<y<320 with one-clock latency -> on yPos=200, vga_r=F on exactly 212 consecutive clocks, starting 2 clocks after xPos==214.
- VGA_FRAME_COUNTER_EN defined, run 3 frames -> frame_start pulses 3 times, 420000 clocks apart; frame_cnt reads 3. Pulse RST low -> frame_cnt=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants and types for the VGA raster timing path.
// Default values describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    // Widths of the raster counters and of each DAC colour channel
    localparam int CNT_W   = 10;
    localparam int COLOR_W = 4;

    // Horizontal timing in pixel clocks
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    // Vertical timing in lines
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Colour latency of the default pixel generators
    localparam int DEF_PIX_LAT  = 1;

    // Timing bits that travel together down the alignment line.
    // Both syncs are active-low, de is active-high.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bits_t;

    // Value of the timing bits while blanked and idle (syncs high, no display)
    localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    // True when lo <= val < hi; used for the sync window decodes
    function automatic logic in_range(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// vga_pipe_delay
// Fixed-depth shift register used to delay the raw timing bits so they
// line up with colour returned by the pixel generators. Each bit has its
// own reset value so syncs can idle high while enables idle low.
// DEPTH = 0 turns the line into a plain wire.
module vga_pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass

            assign dout = din;

        end else begin : g_shift

            logic [WIDTH-1:0] stage [DEPTH];

            // Shift din one stage per clock; reset loads the idle pattern everywhere
            always_ff @(posedge vga_clk or negedge RST) begin
                if (!RST) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];

        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Raster timing master for the DE0 VGA path. Runs the horizontal and
// vertical counters, publishes them as xPos/yPos, and delays the sync and
// blanking decode by PIX_LAT clocks so that it meets the colour coming back
// from the pixel generators. One final register drives the DAC pins, so
// every pin lags xPos/yPos by PIX_LAT+1 clocks.
//
// Optional build macro: VGA_FRAME_COUNTER_EN adds a 16-bit frame_cnt output
// that counts frame_start pulses.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIX_LAT  = DEF_PIX_LAT
) (
    input  logic               vga_clk,
    input  logic               RST,
    output logic [CNT_W-1:0]   xPos,
    output logic [CNT_W-1:0]   yPos,
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               disp_en,
    output logic               frame_start
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter-width copies of the boundaries so every compare is 10 bits wide
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             frame_wrap;

    sync_bits_t raw_sync;
    sync_bits_t dly_sync;

    // Raster counters: h wraps every line, v advances on each h wrap.
    // Both wrapping together takes (last,last) straight to (0,0).
    always_ff @(posedge vga_clk or negedge RST) begin
        if (!RST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + CNT_ONE;
            end
        end else begin
            h_cnt <= h_cnt + CNT_ONE;
        end
    end

    // The counters are already registers, so positions go out directly.
    // They keep counting through blanking; nothing is clamped.
    assign xPos = h_cnt;
    assign yPos = v_cnt;

    // The next clock edge lands on (0,0) exactly when both counters sit at their last value
    assign frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // Decode the undelayed timing bits straight from the counters
    always_comb begin
        raw_sync    = SYNC_IDLE;
        raw_sync.de = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        raw_sync.hs = !in_range(h_cnt, HS_START, HS_END);
        raw_sync.vs = !in_range(v_cnt, VS_START, VS_END);
    end

    // Hold the timing bits back by the generators' colour latency
    vga_pipe_delay #(
        .WIDTH     ($bits(sync_bits_t)),
        .DEPTH     (PIX_LAT),
        .RESET_VAL (SYNC_IDLE)
    ) u_align (
        .vga_clk (vga_clk),
        .RST     (RST),
        .din     (raw_sync),
        .dout    (dly_sync)
    );

    // Pin register: syncs and enable from the aligned line, colour gated to zero outside active video
    always_ff @(posedge vga_clk or negedge RST) begin
        if (!RST) begin
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            disp_en <= 1'b0;
        end else begin
            vga_hs  <= dly_sync.hs;
            vga_vs  <= dly_sync.vs;
            disp_en <= dly_sync.de;
            vga_r   <= dly_sync.de ? red_in   : '0;
            vga_g   <= dly_sync.de ? green_in : '0;
            vga_b   <= dly_sync.de ? blue_in  : '0;
        end
    end

    // Pulse frame_start in the same clock that (0,0) is presented on xPos/yPos
    always_ff @(posedge vga_clk or negedge RST) begin
        if (!RST) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    // Count frame_start pulses; the new count shows up the clock after each pulse
    always_ff @(posedge vga_clk or negedge RST) begin
        if (!RST) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Scoreboard bench for vga_sync_gen using a shrunken raster so several whole
// frames fit in a short run. The stimulus side drives reset and colour each
// clock and pushes what the pins must show after the next edge; a separate
// monitor pops and compares one entry per clock.
// Build with VGA_FRAME_COUNTER_EN defined to also check frame_cnt.
module tb_vga_sync_gen;

    // Small raster: 31 clocks per line, 15 lines per frame
    localparam int HA  = 16;
    localparam int HF  = 4;
    localparam int HS  = 6;
    localparam int HB  = 5;
    localparam int VA  = 8;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int LAT = 2;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int FR  = HT * VT;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic       vga_clk;
    logic       RST;
    logic [9:0] xPos;
    logic [9:0] yPos;
    logic [3:0] red_in;
    logic [3:0] green_in;
    logic [3:0] blue_in;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       disp_en;
    logic       frame_start;
`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] frame_cnt;
`endif

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_idx = 0;
    int   mon_idx  = 0;

    vga_sync_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .PIX_LAT  (LAT)
    ) dut (
        .vga_clk     (vga_clk),
        .RST         (RST),
        .xPos        (xPos),
        .yPos        (yPos),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .disp_en     (disp_en),
        .frame_start (frame_start)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Expected pins after edge e (e = clocks since reset release).
    // The pins describe the raster position LAT+1 clocks back; colour is
    // whatever was on the inputs at edge e.
    function automatic exp_t expected_at(input int e, input bit in_reset,
                                         input logic [3:0] r, input logic [3:0] g,
                                         input logic [3:0] b);
        exp_t t;
        int   pos;
        int   px;
        int   py;
        t    = '0;
        t.hs = 1'b1;
        t.vs = 1'b1;
        if (in_reset) return t;
        t.x  = 10'(e % HT);
        t.y  = 10'((e / HT) % VT);
        t.fs = (e % FR) == 0;
        t.fc = 16'((e - 1) / FR);
        pos  = e - (LAT + 1);
        if (pos >= 0) begin
            px   = pos % HT;
            py   = (pos / HT) % VT;
            t.de = (px < HA) && (py < VA);
            t.hs = !((px >= HA + HF) && (px < HA + HF + HS));
            t.vs = !((py >= VA + VF) && (py < VA + VF + VS));
            if (t.de) begin
                t.r = r;
                t.g = g;
                t.b = b;
            end
        end
        return t;
    endfunction

    // Drive one clock of reset/colour on the falling edge and queue the expected result
    task automatic applyStimulus(input bit rst_n, input bit solid);
        @(negedge vga_clk);
        RST = rst_n;
        if (solid) begin
            red_in   = 4'hF;
            green_in = 4'hF;
            blue_in  = 4'hF;
        end else begin
            red_in   = 4'($urandom);
            green_in = 4'($urandom);
            blue_in  = 4'($urandom);
        end
        if (!rst_n) edge_idx = 0;
        else        edge_idx++;
        q.push_back(expected_at(edge_idx, !rst_n, red_in, green_in, blue_in));
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s clock %0d: got %0h expected %0h", name, mon_idx, actual, expected);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge vga_clk);
            #1;
            mon_idx++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard clock %0d: got empty queue expected an entry", mon_idx);
            end else begin
                e = q.pop_front();
                checkOutput("xPos",        int'(xPos),        int'(e.x));
                checkOutput("yPos",        int'(yPos),        int'(e.y));
                checkOutput("vga_r",       int'(vga_r),       int'(e.r));
                checkOutput("vga_g",       int'(vga_g),       int'(e.g));
                checkOutput("vga_b",       int'(vga_b),       int'(e.b));
                checkOutput("vga_hs",      int'(vga_hs),      int'(e.hs));
                checkOutput("vga_vs",      int'(vga_vs),      int'(e.vs));
                checkOutput("disp_en",     int'(disp_en),     int'(e.de));
                checkOutput("frame_start", int'(frame_start), int'(e.fs));
`ifdef VGA_FRAME_COUNTER_EN
                checkOutput("frame_cnt",   int'(frame_cnt),   int'(e.fc));
`endif
            end
        end
    end

    // Stimulus sequence: reset, solid-white frame, random colours across
    // frame wraps, a 10-clock mid-line reset, more frames, then a one-clock reset glitch
    initial begin
        int target;
        RST      = 1'b0;
        red_in   = '0;
        green_in = '0;
        blue_in  = '0;
        q.push_back(expected_at(0, 1'b1, '0, '0, '0));
        $display("[TB] start: %0d clocks per frame, PIX_LAT %0d", FR, LAT);

        repeat (4) applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < FR; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < FR + 50; i++) applyStimulus(1'b1, 1'b0);

        target = int'($urandom_range(HT - 1, 1));
        for (int i = 0; i < HT && (edge_idx % HT) != target; i++) applyStimulus(1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < 3 * FR + 10; i++) applyStimulus(1'b1, ($urandom % 4) == 0);

        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 2 * HT; i++) applyStimulus(1'b1, 1'b0);

        @(posedge vga_clk);
        #2;
        checkOutput("queue_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
